// File: rtl/uart_pkg.sv
// Shared UART constants: frame shape, state encoding and baud divider helpers.
package uart_pkg;

    // Frame shape: 8N1
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Smallest divider that still leaves a usable mid-bit sample point
    localparam int unsigned MIN_DIVIDER = 4;

    // State encoding, 8 bits wide to match the transmitter side
    typedef enum logic [7:0] {
        IDLE       = 8'h00,
        START_BIT  = 8'h01,
        DATA_BIT   = 8'h02,
        STOP_BIT   = 8'h03,
        BREAK_WAIT = 8'h04
    } uart_state_t;

    // Clocks per serial bit
    function automatic int unsigned calc_divider(input int unsigned fclk,
                                                 input int unsigned fuart);
        return fclk / fuart;
    endfunction

    // Baud counter width: one spare bit above what the divider needs
    function automatic int unsigned calc_cnt_width(input int unsigned divider);
        return $clog2(divider) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous Rx line; resets to the idle level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages come out of reset high so no false start is seen
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid strobe, framing-error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned Fclk  = 50000000,
    parameter int unsigned Fuart = 9600
) (
    input  logic       clk_Rx,
    input  logic       reset,
    input  logic       Rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIVIDER  = calc_divider(Fclk, Fuart);
    localparam int unsigned HALF_DIV = DIVIDER / 2;
    localparam int unsigned CNT_W    = calc_cnt_width(DIVIDER);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);

    uart_state_t          state;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 half_hit;
    logic                 bit_hit;
    logic                 last_bit;

    // Bring the serial line into the clock domain
    uart_rx_sync u_sync (
        .clk   (clk_Rx),
        .reset (reset),
        .d     (Rx_in),
        .q     (rx_s)
    );

    // Sample-point decodes of the baud counter
    always_comb begin
        half_hit = (cnt == CNT_W'(HALF_DIV - 1));
        bit_hit  = (cnt == CNT_W'(DIVIDER - 1));
        last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));
    end

    // Receiver FSM with datapath and registered strobes
    always_ff @(posedge clk_Rx) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START_BIT;
                        busy  <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (half_hit) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Line came back high before mid start bit: glitch
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA_BIT;
                            bit_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA_BIT: begin
                    if (bit_hit) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                        if (last_bit) begin
                            state <= STOP_BIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP_BIT: begin
                    if (bit_hit) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK_WAIT: begin
                    // Hold off until the line idles so a break is not read as a start bit
                    if (rx_s) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
